// File: rtl/mfcc_frame_buffer.sv
// Framing stage for the MFCC pipeline: circular sample buffer with optional
// pre-emphasis, emitting overlapping FRAME_SIZE frames every HOP_SIZE samples.
module mfcc_frame_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_SIZE = 8,
  parameter int HOP_SIZE   = 4,
  parameter int BUF_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] audio_in,
  input  logic                         valid_in,
  input  logic                         preemph_en,
  output logic signed [DATA_WIDTH-1:0] frame_data,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         frame_first,
  output logic                         frame_last,
  output logic [15:0]                  frame_idx,
  output logic                         overflow
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(FRAME_SIZE + 1);
  localparam int PW = 8;
  localparam int EW = DATA_WIDTH + 6;

  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0]   HOP_PTR  = (AW+1)'(HOP_SIZE);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] FR_LAST  = CW'(FRAME_SIZE - 1);
  localparam logic [CW-1:0] HOP_LAST = CW'(HOP_SIZE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PEND_ONE = PW'(1);

  localparam logic signed [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic signed [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [AW:0]                  r_wr_ptr;
  logic [AW:0]                  r_base;
  logic signed [DATA_WIDTH-1:0] r_x_prev;
  logic                         r_started;
  logic [CW-1:0]                r_trig_cnt;
  logic [PW-1:0]                r_pending;
  logic [0:0]                   r_state;
  logic [CW-1:0]                r_out_idx;
  logic [15:0]                  r_frame_idx;
  logic                         r_overflow;

  logic [AW:0]                  w_occ;
  logic                         w_accept;
  logic                         w_complete;
  logic                         w_release;
  logic                         w_streaming;
  logic [AW-1:0]                w_rd_addr;
  logic signed [EW-1:0]         w_x_ext;
  logic signed [EW-1:0]         w_xp_ext;
  logic signed [EW-1:0]         w_prod;
  logic signed [EW-1:0]         w_scaled;
  logic signed [EW-1:0]         w_diff;
  logic signed [DATA_WIDTH-1:0] w_sat;
  logic signed [DATA_WIDTH-1:0] w_store;

  // Occupancy is the distance from the oldest unreleased frame start to the write pointer.
  assign w_occ       = r_wr_ptr - r_base;
  assign w_accept    = valid_in && (w_occ < DEPTH_L);
  assign w_complete  = w_accept && (r_started ? (r_trig_cnt == HOP_LAST)
                                              : (r_trig_cnt == FR_LAST));
  assign w_streaming = (r_state == S_STREAM);
  assign w_release   = w_streaming && frame_ready && (r_out_idx == FR_LAST);
  assign w_rd_addr   = r_base[AW-1:0] + AW'(r_out_idx);

  // x_prev*31 is built as (x_prev<<5) - x_prev, then shifted back down by 32.
  assign w_x_ext  = {{6{audio_in[DATA_WIDTH-1]}}, audio_in};
  assign w_xp_ext = {{6{r_x_prev[DATA_WIDTH-1]}}, r_x_prev};
  assign w_prod   = (w_xp_ext <<< 5) - w_xp_ext;
  assign w_scaled = w_prod >>> 5;
  assign w_diff   = w_x_ext - w_scaled;

  always_comb begin
    w_sat = w_diff[DATA_WIDTH-1:0];
    if (!((&w_diff[EW-1:DATA_WIDTH-1]) || !(|w_diff[EW-1:DATA_WIDTH-1]))) begin
      w_sat = w_diff[EW-1] ? SMIN : SMAX;
    end
  end

  assign w_store = preemph_en ? w_sat : audio_in;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_store;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_x_prev   <= '0;
      r_started  <= 1'b0;
      r_trig_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        r_x_prev <= audio_in;
        if (w_complete) begin
          r_started  <= 1'b1;
          r_trig_cnt <= '0;
        end else begin
          r_trig_cnt <= r_trig_cnt + CNT_ONE;
        end
      end else if (valid_in) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else if (w_complete && !w_release) begin
      r_pending <= r_pending + PEND_ONE;
    end else if (w_release && !w_complete) begin
      r_pending <= r_pending - PEND_ONE;
    end
  end

  // Returning to IDLE after every frame guarantees one idle cycle between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_idx   <= '0;
      r_base      <= '0;
      r_frame_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pending != '0) begin
            r_state   <= S_STREAM;
            r_out_idx <= '0;
          end
        end
        S_STREAM: begin
          if (frame_ready) begin
            if (r_out_idx == FR_LAST) begin
              r_state     <= S_IDLE;
              r_out_idx   <= '0;
              r_base      <= r_base + HOP_PTR;
              r_frame_idx <= r_frame_idx + 16'd1;
            end else begin
              r_out_idx <= r_out_idx + CNT_ONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign frame_valid = w_streaming;
  assign frame_data  = w_streaming ? r_mem[w_rd_addr] : '0;
  assign frame_first = w_streaming && (r_out_idx == '0);
  assign frame_last  = w_streaming && (r_out_idx == FR_LAST);
  assign frame_idx   = r_frame_idx;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_mfcc_frame_buffer.sv
// Self-checking bench for mfcc_frame_buffer: vector table plus multi-cycle
// corner sequences, with a scoreboard of expected frame samples.
`timescale 1ns/1ps
module tb_mfcc_frame_buffer;

  localparam int FS = 8;
  localparam int HS = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] audio_in;
  logic               valid_in;
  logic               preemph_en;
  logic signed [15:0] frame_data;
  logic               frame_valid;
  logic               frame_ready;
  logic               frame_first;
  logic               frame_last;
  logic [15:0]        frame_idx;
  logic               overflow;

  mfcc_frame_buffer #(
    .DATA_WIDTH(16), .FRAME_SIZE(FS), .HOP_SIZE(HS), .BUF_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .audio_in(audio_in), .valid_in(valid_in),
    .preemph_en(preemph_en), .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_first(frame_first), .frame_last(frame_last),
    .frame_idx(frame_idx), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] data;
    logic               first;
    logic               last;
    logic [15:0]        idx;
  } exp_t;

  typedef struct {
    int n;
    int vals[20];
    bit pre;
    bit expOvf;
    int expFrames;
  } vec_t;

  exp_t sbq[$];
  int   modelHist[$];
  int   modelCount;
  int   modelPrev;
  int   modelFrameIdx;
  int   framesSeen;
  bit   lastHsPending;
  int   compared   = 0;
  int   mismatched = 0;
  vec_t vecs[4];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference pre-emphasis with floor division done explicitly, then clamped.
  function automatic int preemph(input int x, input int prev);
    int p;
    int s;
    int y;
    p = prev * 31;
    if (p >= 0) s = p / 32;
    else        s = -((-p + 31) / 32);
    y = x - s;
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic modelReset();
    sbq.delete();
    modelHist.delete();
    modelCount    = 0;
    modelPrev     = 0;
    modelFrameIdx = 0;
    framesSeen    = 0;
    lastHsPending = 0;
  endtask

  // Drive one sample; if the model expects acceptance, store it and push any completed frame.
  task automatic applyStimulus(input int v, input bit pre, input bit accept);
    exp_t e;
    int   y;
    audio_in   = 16'(v);
    valid_in   = 1'b1;
    preemph_en = pre;
    if (accept) begin
      y = pre ? preemph(v, modelPrev) : v;
      modelPrev = v;
      modelHist.push_back(y);
      modelCount++;
      if (modelCount >= FS && ((modelCount - FS) % HS) == 0) begin
        for (int k = 0; k < FS; k++) begin
          e.data  = 16'(modelHist[modelCount - FS + k]);
          e.first = (k == 0);
          e.last  = (k == FS - 1);
          e.idx   = 16'(modelFrameIdx);
          sbq.push_back(e);
        end
        modelFrameIdx++;
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic doReset();
    rst         = 1'b1;
    valid_in    = 1'b0;
    audio_in    = '0;
    preemph_en  = 1'b0;
    frame_ready = 1'b1;
    modelReset();
    #1;
    checkOutput("reset_outputs",
                longint'({frame_valid, frame_first, frame_last, overflow, frame_data, frame_idx}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() > 0) checkOutput("drain_timeout", sbq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input int budget);
    int n;
    n = 0;
    while (!frame_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!frame_valid) checkOutput("wait_valid_timeout", 0, 1);
  endtask

  // Scoreboard consumer: every handshake pops one expected sample.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (lastHsPending) begin
        checkOutput("idle_gap_valid", frame_valid, 0);
        lastHsPending = 0;
      end
      if (frame_valid && frame_ready) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = sbq.pop_front();
          checkOutput("frame_data", frame_data, e.data);
          checkOutput("frame_first", frame_first, e.first);
          checkOutput("frame_last", frame_last, e.last);
          checkOutput("frame_idx", frame_idx, e.idx);
          if (frame_last) begin
            framesSeen++;
            lastHsPending = 1;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [40:0] held;

    for (int t = 0; t < 4; t++) begin
      vecs[t].n = 0;
      vecs[t].pre = 1'b0;
      vecs[t].expOvf = 1'b0;
      vecs[t].expFrames = 0;
      for (int i = 0; i < 20; i++) vecs[t].vals[i] = 0;
    end
    vecs[0].n = 8;  vecs[0].expFrames = 1;
    for (int i = 0; i < 8; i++) vecs[0].vals[i] = i + 1;
    vecs[1].n = 16; vecs[1].expFrames = 3;
    for (int i = 0; i < 16; i++) vecs[1].vals[i] = i + 1;
    vecs[2].n = 8;  vecs[2].pre = 1'b1; vecs[2].expFrames = 1;
    vecs[2].vals[0] = 32;    vecs[2].vals[1] = 32;
    vecs[2].vals[2] = 32767; vecs[2].vals[3] = -32768;
    vecs[3].n = 12; vecs[3].pre = 1'b1; vecs[3].expFrames = 2;
    for (int i = 0; i < 12; i++) vecs[3].vals[i] = (i % 2 == 1) ? (-30000 + i * 7) : (30000 - i * 5);

    for (int t = 0; t < 4; t++) begin
      doReset();
      for (int i = 0; i < vecs[t].n; i++) applyStimulus(vecs[t].vals[i], vecs[t].pre, 1'b1);
      drain(200);
      checkOutput($sformatf("vec%0d_frames", t), framesSeen, vecs[t].expFrames);
      checkOutput($sformatf("vec%0d_overflow", t), overflow, vecs[t].expOvf);
    end

    // Backpressure from the start: the buffer fills at 16 and the next 4 are dropped.
    doReset();
    frame_ready = 1'b0;
    for (int i = 1; i <= 20; i++) applyStimulus(i, 1'b0, i <= 16);
    checkOutput("ovf_set", overflow, 1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("ovf_sticky", overflow, 1);
    frame_ready = 1'b1;
    drain(200);
    checkOutput("ovf_frames", framesSeen, 3);
    checkOutput("ovf_after_drain", overflow, 1);

    // Stall mid-frame: outputs must hold while ready is low.
    doReset();
    for (int i = 1; i <= 8; i++) applyStimulus(i, 1'b0, 1'b1);
    waitValid(50);
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    @(negedge clk);
    held = {frame_valid, frame_first, frame_last, frame_data, frame_idx, 6'd0};
    checkOutput("stall_data", frame_data, 2);
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_hold", {frame_valid, frame_first, frame_last, frame_data, frame_idx, 6'd0}, held);
    end
    @(posedge clk);
    #1;
    frame_ready = 1'b1;
    drain(200);
    checkOutput("stall_frames", framesSeen, 1);

    // Reset while the 4th sample of a frame is on the output.
    doReset();
    for (int i = 1; i <= 8; i++) applyStimulus(i, 1'b0, 1'b1);
    waitValid(50);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_reset_data", frame_data, 4);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", frame_valid, 0);
    checkOutput("midrst_data", frame_data, 0);
    checkOutput("midrst_flags", {frame_first, frame_last, overflow}, 0);
    checkOutput("midrst_idx", frame_idx, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 101; i <= 108; i++) applyStimulus(i, 1'b0, 1'b1);
    drain(200);
    checkOutput("midrst_frames", framesSeen, 1);
    checkOutput("midrst_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
